// File: rtl/wts_channel_volume_mixer.sv
// wts_channel_volume_mixer: per-frame wavetable channel mixer with envelope and volume scaling.
//   nreset     : asynchronous active-low reset
//   clk        : clock
//   start      : frame request, accepted only while idle
//   busy       : frame in progress
//   ch_req     : channel fetch strobe, ch_sel is the channel index (0 when idle)
//   sram_q     : signed sample, envelope code, reg_volume; all valid 1 cycle after ch_req
//   mix        : saturated signed sum of the frame, updated with the one-cycle mix_valid
//   WTS_VOLUME_RAMP_EN : when defined, each channel's effective volume ramps by 1 per frame toward reg_volume
module wts_channel_volume_mixer #(
    parameter int CH_NUM = 5,
    parameter int WAVE_W = 8,
    parameter int VOL_W  = 4,
    parameter int OUT_W  = 11,
    localparam int SW    = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
    input  logic                     nreset,
    input  logic                     clk,
    input  logic                     start,
    output logic                     busy,
    output logic                     ch_req,
    output logic [SW-1:0]            ch_sel,
    input  logic signed [WAVE_W-1:0] sram_q,
    input  logic [7:0]               envelope,
    input  logic [VOL_W-1:0]         reg_volume,
    output logic signed [OUT_W-1:0]  mix,
    output logic                     mix_valid
);
    localparam int CW = $clog2(CH_NUM + 4) + 1;
    localparam int AW = WAVE_W + $clog2(CH_NUM) + 1;
    localparam int XW = AW > OUT_W ? AW : OUT_W;
    localparam int PW = WAVE_W + 8;
    localparam int QW = WAVE_W + VOL_W + 1;
    localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     d1_vld_q, d1_vld_d, w_vld_q, w_vld_d, c_vld_q, c_vld_d;
    logic signed [WAVE_W-1:0] w_q, w_d, c_q, c_d;
    logic [VOL_W-1:0]         v_q, v_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [OUT_W-1:0]  mix_q, mix_d;
    logic                     mix_valid_q, mix_valid_d;
    logic signed [PW-1:0]     p, pb;
    logic signed [QW-1:0]     q, qb;
    logic signed [XW-1:0]     sum;
    logic                     last;
`ifdef WTS_VOLUME_RAMP_EN
    logic [SW-1:0]            sel1_q, sel1_d;
    logic [VOL_W-1:0]         vol_q [CH_NUM];
    logic [VOL_W-1:0]         vol_d [CH_NUM];
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) : (mix_valid_q ? IDLE : RUN);
    end

    always_comb begin
        busy   = state_q == RUN;
        ch_req = busy && cnt_q < CW'(CH_NUM);
        ch_sel = ch_req ? SW'(cnt_q) : '0;
    end

    always_comb begin
        cnt_d    = (busy && !mix_valid_q) ? cnt_q + CW'(1) : '0;
        d1_vld_d = ch_req;
        // Envelope and volume scaling truncate toward zero: bias negatives before dropping fraction bits.
        p        = sram_q * $signed({1'b0, envelope[6:0]});
        pb       = p + (p[PW-1] ? PW'(127) : PW'(0));
        w_d      = envelope[7] ? sram_q : pb[PW-2:7];
        w_vld_d  = d1_vld_q;
`ifdef WTS_VOLUME_RAMP_EN
        sel1_d   = ch_sel;
        vol_d    = vol_q;
        v_d      = vol_q[sel1_q];
        if (d1_vld_q)
            vol_d[sel1_q] = vol_q[sel1_q] < reg_volume ? vol_q[sel1_q] + VOL_W'(1) :
                            vol_q[sel1_q] > reg_volume ? vol_q[sel1_q] - VOL_W'(1) : vol_q[sel1_q];
`else
        v_d      = reg_volume;
`endif
        q        = w_q * $signed({1'b0, v_q});
        qb       = q + (q[QW-1] ? QW'({VOL_W{1'b1}}) : QW'(0));
        c_d      = qb[QW-2:VOL_W];
        c_vld_d  = w_vld_q;
        acc_d    = (!busy && start) ? '0 : c_vld_q ? acc_q + AW'(c_q) : acc_q;
        // The last channel's product joins the sum on its way into mix.
        last        = busy && cnt_q == CW'(CH_NUM + 2);
        sum         = XW'(acc_q) + XW'(c_q);
        mix_d       = !last ? mix_q : sum > MAXV ? MAXV[OUT_W-1:0] : sum < MINV ? MINV[OUT_W-1:0] : sum[OUT_W-1:0];
        mix_valid_d = last;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q       <= '0;
            d1_vld_q    <= 1'b0;
            w_vld_q     <= 1'b0;
            c_vld_q     <= 1'b0;
            w_q         <= '0;
            v_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
`ifdef WTS_VOLUME_RAMP_EN
            sel1_q      <= '0;
            for (int i = 0; i < CH_NUM; i++) vol_q[i] <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            d1_vld_q    <= d1_vld_d;
            w_vld_q     <= w_vld_d;
            c_vld_q     <= c_vld_d;
            w_q         <= w_d;
            v_q         <= v_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
`ifdef WTS_VOLUME_RAMP_EN
            sel1_q      <= sel1_d;
            vol_q       <= vol_d;
`endif
        end
    end

    assign mix       = mix_q;
    assign mix_valid = mix_valid_q;
endmodule

// File: tb/tb_wts_channel_volume_mixer.sv
// tb_wts_channel_volume_mixer: random and directed frames against an arithmetic reference model.
module tb_wts_channel_volume_mixer;
    localparam int N = 5;

    logic clk = 1'b0, nreset = 1'b0, start = 1'b0;
    logic signed [7:0] sram_q = '0;
    logic [7:0] envelope = '0;
    logic [3:0] reg_volume = '0;
    logic busy, ch_req, mix_valid, busy9, ch_req9, mix_valid9;
    logic [2:0] ch_sel, ch_sel9;
    logic signed [10:0] mix;
    logic signed [8:0] mix9;

    wts_channel_volume_mixer dut (
        .nreset(nreset), .clk(clk), .start(start), .busy(busy), .ch_req(ch_req), .ch_sel(ch_sel),
        .sram_q(sram_q), .envelope(envelope), .reg_volume(reg_volume), .mix(mix), .mix_valid(mix_valid)
    );

    wts_channel_volume_mixer #(.OUT_W(9)) dut9 (
        .nreset(nreset), .clk(clk), .start(start), .busy(busy9), .ch_req(ch_req9), .ch_sel(ch_sel9),
        .sram_q(sram_q), .envelope(envelope), .reg_volume(reg_volume), .mix(mix9), .mix_valid(mix_valid9)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic signed [7:0] fs [N];
    logic [7:0] fe [N];
    logic [3:0] fv [N];
    int eff [N];
    int exp_mix = 0, exp_mix9 = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int frame_sum();
        int s = 0;
        int w, v;
        for (int i = 0; i < N; i++) begin
            w = fe[i][7] ? int'(fs[i]) : (int'(fs[i]) * int'(fe[i][6:0])) / 128;
`ifdef WTS_VOLUME_RAMP_EN
            v = eff[i];
            eff[i] += (int'(fv[i]) > eff[i] ? 1 : 0) - (int'(fv[i]) < eff[i] ? 1 : 0);
`else
            v = int'(fv[i]);
`endif
            s += (w * v) / 16;
        end
        return s;
    endfunction

    function automatic int sat(input int s, input int ow);
        int hi = (1 << (ow - 1)) - 1;
        return s > hi ? hi : s < -hi - 1 ? -hi - 1 : s;
    endfunction

    task automatic run_frame(input bit poke);
        int sum;
        bit req_prev = 1'b0;
        logic [2:0] sel_prev = '0;
        @(posedge clk); #1;
        chk("start_busy", busy, 0);
        chk("hold_mix", mix, exp_mix);
        start = 1'b1;
        sum = frame_sum();
        for (int cy = 1; cy <= N + 4; cy++) begin
            @(posedge clk); #1;
            start = poke && cy == 3;
            if (req_prev) begin
                sram_q = fs[sel_prev]; envelope = fe[sel_prev]; reg_volume = fv[sel_prev];
            end else begin
                sram_q = 8'($urandom); envelope = 8'($urandom); reg_volume = 4'($urandom);
            end
            req_prev = ch_req;
            sel_prev = ch_sel;
            chk("busy", busy, 1);
            chk("ch_req", ch_req, cy <= N);
            chk("ch_sel", ch_sel, cy <= N ? cy - 1 : 0);
            chk("mix_valid", mix_valid, cy == N + 4);
            chk("mix_valid9", mix_valid9, cy == N + 4);
            if (cy == N + 4) begin
                exp_mix = sat(sum, 11);
                exp_mix9 = sat(sum, 9);
            end
            chk("mix", mix, exp_mix);
            chk("mix9", mix9, exp_mix9);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_req", ch_req, 0);
            chk("idle_valid", mix_valid, 0);
            chk("idle_mix", mix, exp_mix);
        end
    endtask

    task automatic fill(input logic [7:0] s, input logic [7:0] e, input logic [3:0] v);
        for (int i = 0; i < N; i++) begin fs[i] = s; fe[i] = e; fv[i] = v; end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            fs[i] = 8'($urandom); fe[i] = 8'($urandom); fv[i] = 4'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) eff[i] = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_req", ch_req, 0);
        chk("rst_sel", ch_sel, 0);
        chk("rst_mix", mix, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_mix9", mix9, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        idle(2);
        fill(8'h7F, 8'h80, 4'd15);
        run_frame(0);
        fill(8'h80, 8'h80, 4'd15);
        run_frame(0);
        fill(8'h00, 8'h00, 4'd0);
        fs[0] = 8'h80; fe[0] = 8'h40; fv[0] = 4'd15;
        fs[1] = 8'hFF; fe[1] = 8'h01; fv[1] = 4'd15;
        run_frame(0);
        fill(8'h7F, 8'h80, 4'd15);
        run_frame(1);
        idle(3);
        for (int k = 0; k < 24; k++) begin
            fill_rand();
            run_frame(k % 5 == 2);
            if (k % 3 == 0) idle($urandom_range(1, 3));
        end
        fill_rand();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        exp_mix = 0;
        exp_mix9 = 0;
        for (int i = 0; i < N; i++) eff[i] = 0;
        chk("arst_busy", busy, 0);
        chk("arst_req", ch_req, 0);
        chk("arst_sel", ch_sel, 0);
        chk("arst_mix", mix, 0);
        chk("arst_valid", mix_valid, 0);
        chk("arst_mix9", mix9, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        idle(N + 8);
        for (int k = 0; k < 4; k++) begin
            fill_rand();
            run_frame(0);
        end
        fill(8'h7F, 8'h80, 4'd4);
        for (int k = 0; k < 3; k++) run_frame(0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wts_channel_volume_mixer.md
WTS_CHANNEL_VOLUME_MIXER -- requirements
Module: wts_channel_volume_mixer

Interface
REQ-001 SHALL have parameter CH_NUM, default 5, meaning the number of channels processed per frame (range 1..32).
REQ-002 SHALL have parameter WAVE_W, default 8, meaning the width of the signed wave sample.
REQ-003 SHALL have parameter VOL_W, default 4, meaning the width of the unsigned channel volume.
REQ-004 SHALL have parameter OUT_W, default 11, meaning the width of the signed mixed output (OUT_W >= WAVE_W).
REQ-005 SHALL have ports: nreset in 1, asynchronous, active-low reset; clk in 1, clock.
REQ-006 SHALL have ports: start in 1, frame request; busy out 1, frame in progress.
REQ-007 SHALL have ports: ch_req out 1, channel fetch strobe; ch_sel out clog2(CH_NUM) (min 1), index of the channel being fetched.
REQ-008 SHALL have ports: sram_q in WAVE_W, signed sample; envelope in 8, envelope code; reg_volume in VOL_W, volume; all valid exactly 1 cycle after ch_req.
REQ-009 SHALL have ports: mix out OUT_W, signed mixed result; mix_valid out 1, one-cycle result strobe.

Function
REQ-010 SHALL implement states IDLE and RUN: IDLE->RUN on start=1; RUN->IDLE in the cycle mix_valid is asserted.
REQ-011 SHALL assert busy in every cycle the state is RUN, and SHALL ignore start while busy=1.
REQ-012 SHALL assert ch_req in the CH_NUM cycles following the start cycle, with ch_sel = 0, 1, ..., CH_NUM-1 in order, and SHALL hold ch_sel at 0 when ch_req=0.
REQ-013 SHALL compute per channel w = envelope[7] ? sram_q : (sram_q * envelope[6:0]) / 128, signed, rounded toward zero.
REQ-014 SHALL compute per channel c = (w * v) / 2^VOL_W, signed, rounded toward zero, with v the volume defined in REQ-023/024; v=0 yields 0.
REQ-015 SHALL accumulate c over all CH_NUM channels at width WAVE_W+clog2(CH_NUM)+1 without internal overflow, clearing the accumulator on frame start.
REQ-016 SHALL saturate the sum to the OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1] when loading mix.
REQ-017 SHALL pulse mix_valid for exactly one cycle, CH_NUM+4 cycles after the cycle in which start was accepted, with mix updated in that same cycle.
REQ-018 SHALL hold mix constant between mix_valid pulses.
REQ-019 SHALL accept a new start in the cycle after mix_valid, giving back-to-back frames every CH_NUM+5 cycles.
REQ-020 SHALL pipeline the two multiplies in separate register stages; no combinational path from sram_q to mix.

Reset
REQ-021 SHALL on nreset=0, asynchronously and regardless of state: force IDLE; drive busy=0, ch_req=0, ch_sel=0, mix=0, mix_valid=0; clear all pipeline and accumulator registers.
REQ-022 SHALL discard a frame interrupted by reset and produce no mix_valid for it after reset release.

Configuration
REQ-023 SHALL, with macro WTS_VOLUME_RAMP_EN defined, keep a per-channel effective volume register (reset 0) that steps by +1 or -1 toward reg_volume once per frame when that channel is fetched, and use the pre-step value as v.
REQ-024 SHALL, without WTS_VOLUME_RAMP_EN, use reg_volume directly as v and contain no per-channel volume storage.

Verification
REQ-025 SHALL cover full-scale: CH_NUM=5, all channels sram_q=8'h7F, envelope=8'h80, reg_volume=15 -> mix=595 (5*119), mix_valid at start+9.
REQ-026 SHALL cover negative/rounding: ch0 sram_q=8'h80, envelope=8'h40, vol=15 (-60); ch1 sram_q=8'hFF, envelope=8'h01, vol=15 (0); others vol=0 -> mix=-60.
REQ-027 SHALL cover saturation: OUT_W=9, stimulus of REQ-025 -> mix=255; all sram_q=8'h80, envelope=8'h80, vol=15 -> mix=-256.
REQ-028 SHALL cover control: start pulsed again during busy -> ignored, one mix_valid only; nreset asserted mid-RUN -> all outputs 0, no stray mix_valid.
REQ-029 SHALL cover ramp with WTS_VOLUME_RAMP_EN: stimulus of REQ-025 with reg_volume 0->4 after reset -> successive frames mix=0, 35, 75, 115, 155, 155 (5*{0,7,15,23,31}).
